// File: rtl/debug_pipeline_controller_if.sv
// Command and transmit byte handshakes between the debug controller and the UART.
interface debug_pipeline_controller_if;
  logic       Cmd_Valid;
  logic [7:0] Cmd_Code;
  logic       Cmd_Ready;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Ready;

  modport master (output Cmd_Valid, Cmd_Code, Tx_Ready,
                  input  Cmd_Ready, Tx_Data, Tx_Valid);
  modport slave  (input  Cmd_Valid, Cmd_Code, Tx_Ready,
                  output Cmd_Ready, Tx_Data, Tx_Valid);
endinterface

// File: rtl/debug_pipeline_controller.sv
// Debug sequencer: run/step/halt gating of the pipeline and a byte-wise register dump
// through a borrowed register-file read port.
module debug_pipeline_controller #(
  parameter int NUM_REGS = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  debug_pipeline_controller_if.slave bus,
  input  logic        Halt_Detected,
  output logic        PipeEnable,
  output logic        DbgRegSel,
  output logic [4:0]  DbgRegAddr,
  input  logic [31:0] DbgRegData,
  output logic        Halted,
  output logic [31:0] CycleCount
);

  typedef enum logic [2:0] {IDLE, RUN, STEP, DUMP_ADDR, DUMP_SEND} state_t;

  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_HALT = 8'h68;

  state_t      state, stateNext;
  logic [4:0]  regIdx;
  logic [1:0]  byteCnt;
  logic [31:0] shiftReg;
  logic [31:0] cycleCnt;
  logic        cmdAccept, txFire, lastByte, lastReg;

  assign cmdAccept  = bus.Cmd_Valid && bus.Cmd_Ready;
  assign txFire     = bus.Tx_Valid && bus.Tx_Ready;
  assign lastByte   = (byteCnt == 2'd3);
  assign lastReg    = (regIdx == 5'(NUM_REGS - 1));
  assign CycleCount = cycleCnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (cmdAccept) begin
        if (bus.Cmd_Code == CMD_CONT)      stateNext = RUN;
        else if (bus.Cmd_Code == CMD_STEP) stateNext = STEP;
        else if (bus.Cmd_Code == CMD_DUMP) stateNext = DUMP_ADDR;
      end
      // A halt instruction and an 'h' command land in the same place, so no priority needed
      RUN:       if (Halt_Detected || (cmdAccept && bus.Cmd_Code == CMD_HALT)) stateNext = IDLE;
      STEP:      stateNext = IDLE;
      DUMP_ADDR: stateNext = DUMP_SEND;
      DUMP_SEND: if (txFire && lastByte) stateNext = lastReg ? IDLE : DUMP_ADDR;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    PipeEnable    = (state == RUN) || (state == STEP);
    DbgRegSel     = (state == DUMP_ADDR);
    DbgRegAddr    = (state == DUMP_ADDR) ? regIdx : 5'd0;
    bus.Tx_Valid  = (state == DUMP_SEND);
    bus.Tx_Data   = (state == DUMP_SEND) ? shiftReg[31:24] : 8'd0;
    bus.Cmd_Ready = (state == IDLE) || (state == RUN);
    Halted        = (state == IDLE);
  end

  // Dump datapath: register index, byte counter and MSB-first shift register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regIdx   <= 5'd0;
      byteCnt  <= 2'd0;
      shiftReg <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (cmdAccept && bus.Cmd_Code == CMD_DUMP) regIdx <= 5'd0;
        DUMP_ADDR: begin
          shiftReg <= DbgRegData;
          byteCnt  <= 2'd0;
        end
        DUMP_SEND: if (txFire) begin
          shiftReg <= {shiftReg[23:0], 8'd0};
          byteCnt  <= byteCnt + 2'd1;
          if (lastByte) regIdx <= lastReg ? 5'd0 : regIdx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)           cycleCnt <= 32'd0;
    else if (PipeEnable) cycleCnt <= cycleCnt + 32'd1;
  end

endmodule

// File: doc/debug_pipeline_controller.md
# debug_pipeline_controller

Debug-mode sequencer for the five-stage MIPS pipeline. It decodes single-byte commands from the UART receiver, gates pipeline advance (run, single-step, halt) and shares register-file read port 1 between the ID stage and a register dump streamed byte-wise to the UART transmitter. At top level, `PipeEnable` is ANDed into every pipeline write enable (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, register-file write). `DbgRegSel` drives the ReadRegister1 address mux.

## Interface
- `NUM_REGS`, default 32: registers dumped per `d` command, legal range 1..32.
- `Clock` — input, 1: system clock, rising edge.
- `Reset` — input, 1: asynchronous, active-high.
- `Cmd_Valid` — input, 1: command byte available from the UART receiver.
- `Cmd_Code` — input, 8: command byte.
- `Cmd_Ready` — output, 1: controller accepts a command this cycle.
- `Halt_Detected` — input, 1: halt instruction has reached WB.
- `PipeEnable` — output, 1: pipeline may advance this cycle.
- `DbgRegSel` — output, 1: register read port 1 is owned by the controller.
- `DbgRegAddr` — output, 5: register index on read port 1 while `DbgRegSel` is high.
- `DbgRegData` — input, 32: ReadData1 from the register file, combinational.
- `Tx_Data` — output, 8: byte to the transmitter.
- `Tx_Valid` — output, 1: `Tx_Data` is valid.
- `Tx_Ready` — input, 1: transmitter accepts the byte.
- `Halted` — output, 1: controller is in IDLE.
- `CycleCount` — output, 32: number of cycles with `PipeEnable` high since reset.

## Operation
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_SEND.
- Reset state is IDLE.
- Outputs at reset:
  - `PipeEnable`=0, `DbgRegSel`=0, `DbgRegAddr`=0, `Tx_Valid`=0, `Tx_Data`=0.
  - `Cmd_Ready`=1, `Halted`=1, `CycleCount`=0.
  - Internal register index and byte counter are 0.
- A command is accepted on a rising edge where `Cmd_Valid`&&`Cmd_Ready`.
- `Cmd_Ready` is 1 in IDLE and RUN, and 0 in all other states.
- Accepted commands in IDLE:
  - 8'h63 `c` -> RUN.
  - 8'h73 `s` -> STEP.
  - 8'h64 `d` -> DUMP_ADDR with index 0.
  - Any other byte is consumed with no effect.
- Accepted commands in RUN:
  - 8'h68 `h` -> IDLE.
  - Any other byte is consumed with no effect.
- RUN: `PipeEnable`=1. `Halt_Detected`=1 -> IDLE at the next edge; it has equal priority with `h`.
- STEP: `PipeEnable`=1 for exactly one cycle, then IDLE unconditionally. `Halt_Detected` is ignored because the result is already IDLE.
- DUMP_ADDR (one cycle):
  - `DbgRegSel`=1 and `DbgRegAddr`=index.
  - At the end edge, the 32-bit shift register captures `DbgRegData`, the byte counter clears, and the state goes to DUMP_SEND.
- DUMP_SEND:
  - `Tx_Valid`=1 and `Tx_Data`=shift[31:24], so bytes go out MSB first.
  - On each `Tx_Valid`&&`Tx_Ready` edge: shift <<= 8 and the byte counter increments.
  - After the 4th byte: if index == NUM_REGS-1, go to IDLE and clear the index; otherwise index+1 and go to DUMP_ADDR.
- `Tx_Data` and `Tx_Valid` hold stable while `Tx_Valid`&&!`Tx_Ready`.
- `PipeEnable`=0 throughout a dump, so the pipeline never reads through the borrowed port.
- `DbgRegSel`=0 outside DUMP_ADDR. `DbgRegAddr` is 0 when `DbgRegSel`=0.
- `CycleCount` increments on every edge where `PipeEnable`=1 and wraps at 2^32-1 -> 0 with no flag.
- `Halted`=1 only in IDLE.

## Timing
- All outputs are decoded from registered state.
- There is no combinational path from `Cmd_*` or `Tx_Ready` to any output except through state.
- Command -> `PipeEnable` latency is 1 cycle: accept at edge N, enable high in cycle N+1.
- `h` or `Halt_Detected` sampled at edge N -> `PipeEnable`=0 from cycle N+1. An enable pulse cannot extend past that.
- A `d` accepted at edge N gives `DbgRegSel`=1 in cycle N+1 and first `Tx_Valid` in cycle N+2.
- With `Tx_Ready` held at 1, a full dump takes NUM_REGS*5 cycles: 160 cycles at the default.
- `Halt_Detected` is sampled only in RUN. It has no effect in IDLE or in dump states.
- Asynchronous `Reset` in any state, including mid-byte in DUMP_SEND, immediately forces all reset values. A partially sent register is not resumed.

## Test plan
- Reset, then `c`, wait 10 cycles, then `h` -> `PipeEnable` high for exactly 11 cycles (acceptance of `c` through acceptance of `h`); `CycleCount`=11; `Halted`=1.
- From IDLE, issue `s` three times, each separated by idle cycles -> three single-cycle `PipeEnable` pulses; `CycleCount`=3; `Cmd_Ready`=0 in each STEP cycle.
- `c`, then assert `Halt_Detected` and `Cmd_Valid`/`h` in the same cycle -> one transition to IDLE; no extra enable cycle; `h` is consumed.
- Preload r1=32'hDEADBEEF and r2=32'h01020304, `d` with `Tx_Ready`=1 -> 128 bytes; bytes 4..7 are DE AD BE EF and bytes 8..11 are 01 02 03 04; `DbgRegAddr` steps 0..31; the controller returns to IDLE.
- `d` with `Tx_Ready` toggling randomly -> `Tx_Data` stable while stalled and the byte stream is identical to the previous scenario. Assert `Reset` mid-register -> `Tx_Valid`=0 immediately; the next `d` restarts at r0.
- Preset `CycleCount` to 32'hFFFFFFFE and run 3 cycles -> value sequence FFFFFFFF, 0, 1.
